// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes / InvSubBytes engine: one 128-bit block is pushed
// through LANES forward/inverse S-box lookups per cycle until all 16 bytes are done.

module sub_bytes_lane (
    input  logic       mode,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Index 0 sits in the most significant byte of each concatenation.
    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:255][7:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign dout = mode ? INV[din] : FWD[din];
endmodule

module sub_bytes_seq #(
    parameter int LANES   = 4,
    parameter bit REG_OUT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] newstate,
    output logic         busy
);
    if (LANES < 1 || 16 % LANES != 0) begin : g_lanes_chk
        $error("sub_bytes_seq: LANES must divide 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

    st_t                    st_q, st_d;
    logic [15:0][7:0]       blk_q, res_q;
    logic                   mode_q;
    logic [3:0]             idx_q;
    logic [LANES-1:0][7:0]  lane_in, lane_out;
    logic                   last_chunk;

    // The index moves in whole LANES steps, so the final chunk starts at 16-LANES.
    assign last_chunk = (idx_q == 4'(16 - LANES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st_q <= IDLE;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (in_valid)   st_d = BUSY;
            BUSY:    if (last_chunk) st_d = DONE;
            DONE:    if (out_ready)  st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = blk_q[idx_q + 4'(l)];
        sub_bytes_lane u_lane (
            .mode (mode_q),
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q  <= '0;
            res_q  <= '0;
            mode_q <= 1'b0;
            idx_q  <= '0;
        end else if (st_q == IDLE && in_valid) begin
            blk_q  <= state;
            mode_q <= mode;
            idx_q  <= '0;
        end else if (st_q == BUSY) begin
            for (int l = 0; l < LANES; l++)
                res_q[idx_q + 4'(l)] <= lane_out[l];
            idx_q <= idx_q + 4'(LANES);
        end
    end

    assign in_ready  = (st_q == IDLE);
    assign out_valid = (st_q == DONE);
    assign busy      = (st_q != IDLE);

    if (REG_OUT) begin : g_out_reg
        assign newstate = res_q;
    end else begin : g_out_gated
        assign newstate = out_valid ? res_q : '0;
    end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Drives three sub_bytes_seq instances (LANES 1/4/16) in lockstep and checks them
// against S-boxes derived from GF(2^8) arithmetic.

module tb_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] state = '0;
    logic [2:0]   in_ready_v, out_valid_v, busy_v;
    logic [127:0] ns [3];

    int n_chk = 0;
    int n_pass = 0;
    int lat_exp [3] = '{16, 4, 1};
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .state(state), .out_valid(out_valid_v[0]), .out_ready(out_ready), .newstate(ns[0]),
        .busy(busy_v[0]));
    sub_bytes_seq #(.LANES(4)) u_l4 (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .state(state), .out_valid(out_valid_v[1]), .out_ready(out_ready), .newstate(ns[1]),
        .busy(busy_v[1]));
    sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .state(state), .out_valid(out_valid_v[2]), .out_ready(out_ready), .newstate(ns[2]),
        .busy(busy_v[2]));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [15:0] bb;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            bb = {inv, inv};
            s = inv ^ bb[14:7] ^ bb[13:6] ^ bb[12:5] ^ bb[11:4] ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic m);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = m ? isb[s[8*k +: 8]] : sb[s[8*k +: 8]];
        return r;
    endfunction

    task automatic run(input logic m, input logic [127:0] s, input string tag);
        logic [127:0] exp = model(s, m);
        int lat [3] = '{0, 0, 0};
        @(negedge clk);
        state = s; mode = m; in_valid = 1'b1;
        chk({tag, " in_ready"}, 128'(in_ready_v), 128'(3'b111));
        @(posedge clk); #1;
        in_valid = 1'b0;
        state = {$urandom, $urandom, $urandom, $urandom};
        mode = ~m;
        for (int e = 1; e <= 20 && out_valid_v != 3'b111; e++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (out_valid_v[i] && lat[i] == 0) lat[i] = e;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s lat[%0d]", tag, i), 128'(lat[i]), 128'(lat_exp[i]));
            chk($sformatf("%s data[%0d]", tag, i), ns[i], exp);
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " rel in_ready"}, 128'(in_ready_v), 128'(3'b111));
        chk({tag, " rel out_valid"}, 128'(out_valid_v), 128'(0));
    endtask

    initial begin
        logic [127:0] orig = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
        logic [127:0] fwd  = 128'hd4e0b81e27bfb44111985d52aef1e530;
        logic [127:0] blk_b = 128'h00112233445566778899aabbccddeeff;
        build_tables();

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 128'(in_ready_v), 128'(3'b111));
        chk("rst out_valid", 128'(out_valid_v), 128'(0));
        chk("rst busy", 128'(busy_v), 128'(0));
        for (int i = 0; i < 3; i++) chk($sformatf("rst ns[%0d]", i), ns[i], '0);
        @(negedge clk);
        reset = 1'b0;

        // Known FIPS-197 vector, forward then back.
        run(1'b0, orig, "fips fwd");
        for (int i = 0; i < 3; i++) chk($sformatf("fips const[%0d]", i), ns[i], fwd);
        release_out("fips fwd");
        run(1'b1, fwd, "fips inv");
        for (int i = 0; i < 3; i++) chk($sformatf("fips orig[%0d]", i), ns[i], orig);
        release_out("fips inv");

        run(1'b0, '0, "zero fwd");
        for (int i = 0; i < 3; i++) chk($sformatf("zero 63[%0d]", i), ns[i], {16{8'h63}});
        release_out("zero fwd");
        run(1'b1, {16{8'h63}}, "63 inv");
        for (int i = 0; i < 3; i++) chk($sformatf("63 zero[%0d]", i), ns[i], '0);
        release_out("63 inv");

        // Back-pressure: result held, foreign block offered but never taken.
        run(1'b0, orig, "hold");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0]; state = blk_b; mode = 1'b1;
            @(posedge clk); #1;
            chk("hold out_valid", 128'(out_valid_v), 128'(3'b111));
            chk("hold in_ready", 128'(in_ready_v), 128'(0));
            for (int i = 0; i < 3; i++) chk($sformatf("hold ns[%0d]", i), ns[i], fwd);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("hold rel busy", 128'(busy_v), 128'(0));
        chk("hold rel in_ready", 128'(in_ready_v), 128'(3'b111));
        @(posedge clk); #1;
        chk("hold no accept", 128'(busy_v), 128'(0));
        for (int i = 0; i < 3; i++) chk($sformatf("idle keep[%0d]", i), ns[i], fwd);

        // Asynchronous reset during the second BUSY cycle.
        @(negedge clk);
        state = blk_b; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst in_ready", 128'(in_ready_v), 128'(3'b111));
        chk("midrst out_valid", 128'(out_valid_v), 128'(0));
        chk("midrst busy", 128'(busy_v), 128'(0));
        for (int i = 0; i < 3; i++) chk($sformatf("midrst ns[%0d]", i), ns[i], '0);
        @(negedge clk);
        reset = 1'b0;
        run(1'b1, blk_b, "post rst");
        release_out("post rst");

        // Every byte value through both tables.
        for (int m = 0; m < 2; m++)
            for (int j = 0; j < 16; j++) begin
                logic [127:0] s;
                for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(16*j + k);
                run(m[0], s, $sformatf("exh m%0d j%0d", m, j));
                release_out("exh");
            end

        for (int r = 0; r < 20; r++) begin
            run(1'($urandom), {$urandom, $urandom, $urandom, $urandom}, $sformatf("rand %0d", r));
            if (r % 3 == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            release_out("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
